grid_ram_write_ctrl: RTL
========================

Name: grid_ram_write_ctrl

Overview:
- Write-side controller for the 16-cell colour RAM (AW=4, DW=3) that feeds the 640x480 VGA grid renderer.
- Shares the RAM write port between two requesters:
  - a single-cell update port (game logic, req/ack);
  - an internal fill engine that paints every cell one colour.
- Sequences fills, arbitrates collisions and optionally restricts writes to vertical blanking.

Parameters:
- AW, 4, RAM address width; DEPTH = 2**AW cells.
- DW, 3, colour width (RGB 1-1-1).
- RESET_FILL, 1, 1 = run an automatic fill after reset release.
- RESET_COLOR, 3'b000, colour used by the reset fill.

Ports:
- clk  in  1  system clock (same clock as the RAM write port).
- rst  in  1  asynchronous active-low reset.
- req_a  in  1  single-cell write request; held high until ack_a.
- addr_a  in  AW  cell index for the request; stable while req_a=1.
- data_a  in  DW  colour for the request; stable while req_a=1.
- ack_a  out  1  one-cycle pulse; the write is issued in the same cycle.
- fill_start  in  1  one-cycle pulse; starts a full-grid fill.
- fill_color  in  DW  fill colour; sampled on fill_start.
- fill_busy  out  1  high while a fill is in progress.
- fill_done  out  1  one-cycle pulse after the last cell is written.
- vsync_n  in  1  VGA vertical sync (active-low, asynchronous to clk); used only with VBLANK_GATE_EN.
- ram_addr  out  AW  RAM write address.
- ram_data  out  DW  RAM write data.
- ram_we  out  1  RAM write enable.

Behaviour:
- All outputs are registered.
- Reset values:
  - ram_we=0, ram_addr=0, ram_data=0, ack_a=0, fill_done=0.
  - fill_busy=RESET_FILL; the state is FILL when RESET_FILL=1, otherwise IDLE.
- State machine: IDLE, WRITE_A, FILL, DONE.
- IDLE:
  - fill_start=1: latch fill_color, cnt=0, go to FILL. If req_a is also high, the fill wins and req_a waits.
  - Else req_a=1: go to WRITE_A.
- WRITE_A (one cycle):
  - ram_we=1, ram_addr=addr_a, ram_data=data_a, ack_a=1.
  - Return to IDLE. A request still held after ack is served again, so throughput is at most one write per 2 cycles.
- FILL:
  - Each permitted cycle: ram_we=1, ram_addr=cnt, ram_data=latched colour, cnt+1.
  - After the write with cnt=DEPTH-1, go to DONE. This takes exactly DEPTH write cycles; cnt never wraps.
  - fill_start is ignored. req_a is stalled (no ack) until the fill completes.
- DONE (one cycle): fill_done=1, fill_busy=0, ram_we=0; go to IDLE.
- Reset fill: after rst deasserts, fills with RESET_COLOR. Timing and behaviour are identical to a commanded fill, including the fill_done pulse.
- Reset asserted mid-operation: the FSM goes to reset state immediately and ram_we drops asynchronously. A partial fill is not resumed, except that a new reset fill runs when RESET_FILL=1.
- ram_we=0 in every cycle not listed above; ram_addr and ram_data hold their last values.

Optional Feature:
- Macro: VBLANK_GATE_EN.
- Defined:
  - vsync_n passes through a 2-flop synchronizer.
  - Writes are permitted only while the synchronized vsync_n=0.
  - WRITE_A is not entered (no ack) outside the window.
  - FILL pauses with cnt held and ram_we=0, then resumes where it stopped when the window reopens.
  - fill_busy stays high while paused.
- Undefined: vsync_n is unused; writes are issued whenever the FSM requests them.

Decomposition:
- Shared package (grid_pkg):
  - AW/DW defaults and GRID_CELLS=16.
  - Colour constants RED=3'b100, GREEN=3'b010, BLUE=3'b001, BLACK=3'b000.
  - FSM state encoding.
- One natural sub-module: sync_2ff, the generic 1-bit double-flop synchronizer used for vsync_n.

Test Plan:
- RESET_FILL=1, RESET_COLOR=3'b001, rst released:
  - 16 consecutive ram_we cycles, ram_addr 0..15, ram_data=001;
  - fill_done pulses 1 cycle later and fill_busy falls.
- Idle, req_a=1, addr_a=5, data_a=3'b100:
  - ack_a and ram_we high in the same cycle with addr 5 / data 100;
  - req_a dropped after ack gives exactly one write.
- fill_start and req_a in the same cycle (fill_color=010, addr_a=3):
  - the fill runs 16 writes first;
  - ack_a and the write to addr 3 follow after DONE.
- rst asserted after 7 fill writes:
  - ram_we=0 immediately;
  - with RESET_FILL=0 no further writes occur, fill_busy=0 and no fill_done pulse.
- VBLANK_GATE_EN defined, vsync_n high during a fill:
  - no writes and cnt frozen;
  - vsync_n low resumes at the held address, 2-3 cycle synchronizer latency;
  - total writes still 16.
- fill_start pulsed again during a fill: ignored; a single fill_done pulse at the end.

Source files
------------

// File: rtl/grid_pkg.sv
// ============================================================================
//  Module      : grid_pkg
//  Description : Shared constants, colours and FSM encoding for the grid
//                colour-RAM write controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package grid_pkg;

  localparam int GRID_AW    = 4;
  localparam int GRID_DW    = 3;
  localparam int GRID_CELLS = 16;

  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] BLACK = 3'b000;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_WRITE_A = 2'd1;
  localparam state_t ST_FILL    = 2'd2;
  localparam state_t ST_DONE    = 2'd3;

endpackage

`default_nettype wire

// File: rtl/grid_ram_write_ctrl_if.sv
// ============================================================================
//  Module      : grid_ram_write_ctrl_if
//  Description : Request, fill-control and RAM write-port bundle of the grid
//                colour-RAM write controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface grid_ram_write_ctrl_if
  import grid_pkg::*;
#(
  parameter int AW = GRID_AW,
  parameter int DW = GRID_DW
);

  logic          req_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] data_a;
  logic          ack_a;
  logic          fill_start;
  logic [DW-1:0] fill_color;
  logic          fill_busy;
  logic          fill_done;
  logic          vsync_n;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_we;

  modport master (
    output req_a, addr_a, data_a, fill_start, fill_color, vsync_n,
    input  ack_a, fill_busy, fill_done, ram_addr, ram_data, ram_we
  );

  modport slave (
    input  req_a, addr_a, data_a, fill_start, fill_color, vsync_n,
    output ack_a, fill_busy, fill_done, ram_addr, ram_data, ram_we
  );

endinterface

`default_nettype wire

// File: rtl/grid_ram_write_ctrl_sync_2ff.sv
// ============================================================================
//  Module      : sync_2ff
//  Description : Generic 1-bit double-flop synchronizer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/grid_ram_write_ctrl.sv
// ============================================================================
//  Module      : grid_ram_write_ctrl
//  Description : Arbitrates the colour-RAM write port between single-cell
//                requests and a whole-grid fill engine. Optional macro
//                VBLANK_GATE_EN restricts writes to vertical blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module grid_ram_write_ctrl
  import grid_pkg::*;
#(
  parameter int            AW          = GRID_AW,
  parameter int            DW          = GRID_DW,
  parameter int            RESET_FILL  = 1,
  parameter logic [DW-1:0] RESET_COLOR = BLACK
) (
  input  logic                 clk,
  input  logic                 rst_n,
  grid_ram_write_ctrl_if.slave bus
);

  localparam logic [AW-1:0] c_LAST        = '1;
  localparam state_t        c_RESET_STATE = (RESET_FILL != 0) ? ST_FILL : ST_IDLE;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_cnt,   w_cnt_nxt;
  logic [DW-1:0] r_color, w_color_nxt;
  logic          r_we,    w_we_nxt;
  logic [AW-1:0] r_addr,  w_addr_nxt;
  logic [DW-1:0] r_data,  w_data_nxt;
  logic          r_ack,   w_ack_nxt;
  logic          r_busy,  w_busy_nxt;
  logic          r_done,  w_done_nxt;
  logic          w_permit;

`ifdef VBLANK_GATE_EN
  logic w_vsync_n_sync;

  // Reset to "outside the window" so nothing is written before vsync is seen.
  sync_2ff #(.RESET_VAL(1'b1)) u_vsync_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.vsync_n),
    .q     (w_vsync_n_sync)
  );

  assign w_permit = ~w_vsync_n_sync;
`else
  logic w_unused_vsync_n;
  assign w_unused_vsync_n = bus.vsync_n;
  assign w_permit         = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_RESET_STATE;
      r_cnt   <= '0;
      r_color <= RESET_COLOR;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_ack   <= 1'b0;
      r_busy  <= (RESET_FILL != 0);
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_color <= w_color_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_ack   <= w_ack_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_color_nxt = r_color;
    case (r_state)
      ST_IDLE: begin
        if (bus.fill_start) begin
          w_state_nxt = ST_FILL;
          w_cnt_nxt   = '0;
          w_color_nxt = bus.fill_color;
        end else if (bus.req_a && w_permit) begin
          w_state_nxt = ST_WRITE_A;
        end
      end
      ST_WRITE_A: w_state_nxt = ST_IDLE;
      ST_FILL: begin
        if (w_permit) begin
          if (r_cnt == c_LAST) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; they become visible in the cycle
  // the FSM spends in the state that issues them.
  always_comb begin
    w_we_nxt   = 1'b0;
    w_addr_nxt = r_addr;
    w_data_nxt = r_data;
    w_ack_nxt  = 1'b0;
    w_busy_nxt = r_busy;
    w_done_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.fill_start) begin
          w_busy_nxt = 1'b1;
        end else if (bus.req_a && w_permit) begin
          w_we_nxt   = 1'b1;
          w_ack_nxt  = 1'b1;
          w_addr_nxt = bus.addr_a;
          w_data_nxt = bus.data_a;
        end
      end
      ST_FILL: begin
        if (w_permit) begin
          w_we_nxt   = 1'b1;
          w_addr_nxt = r_cnt;
          w_data_nxt = r_color;
        end
      end
      ST_DONE: begin
        w_done_nxt = 1'b1;
        w_busy_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.ram_we    = r_we;
  assign bus.ram_addr  = r_addr;
  assign bus.ram_data  = r_data;
  assign bus.ack_a     = r_ack;
  assign bus.fill_busy = r_busy;
  assign bus.fill_done = r_done;

endmodule

`default_nettype wire
